// File: rtl/z80fi_pkg.sv
// ---------------------------------------------------------------------------
// z80fi_pkg
//   Shared types and constants for the Z80 formal-interface trace generator.
//   - z80fi_regs_t         : packed snapshot of the architectural registers
//   - z80fi_state_e        : trace generator FSM states (IDLE, COLLECT)
//   - Z80FI_INSN_MAX_BYTES : default number of instruction bytes captured
// ---------------------------------------------------------------------------
package z80fi_pkg;

  localparam int Z80FI_INSN_MAX_BYTES = 4;

  typedef struct packed {
    logic [15:0] ip;
    logic [15:0] sp;
    logic [15:0] af;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] af2;
    logic [15:0] bc2;
    logic [15:0] de2;
    logic [15:0] hl2;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [7:0]  i;
    logic [7:0]  r;
    logic        iff1;
    logic        iff2;
    logic [1:0]  im;
  } z80fi_regs_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } z80fi_state_e;

endpackage

// File: rtl/z80fi_insn_collector.sv
// ---------------------------------------------------------------------------
// z80fi_insn_collector
//   Byte buffer for one instruction. Bytes are packed little-end first:
//   byte 0 in insn[7:0], byte 1 in insn[15:8], and so on. Unused bytes stay
//   zero. Once INSN_BYTES bytes are held, further pushes are dropped.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   clear      : start a new instruction (empty buffer, len = 0)
//   push       : append push_byte; with clear it becomes byte 0
//   push_byte  : byte to append
//   insn       : captured bytes, 8*INSN_BYTES wide
//   len        : number of bytes captured, saturates at INSN_BYTES
// ---------------------------------------------------------------------------
module z80fi_insn_collector
  import z80fi_pkg::*;
#(
  parameter int INSN_BYTES = Z80FI_INSN_MAX_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [7:0]              push_byte,
  output logic [8*INSN_BYTES-1:0] insn,
  output logic [2:0]              len
);

  localparam int         INSN_W  = 8 * INSN_BYTES;
  localparam logic [2:0] LEN_MAX = 3'(INSN_BYTES);

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      insn <= '0;
      len  <= '0;
    end else if (clear) begin
      if (push) begin
        insn <= {{(INSN_W-8){1'b0}}, push_byte};
        len  <= 3'd1;
      end else begin
        insn <= '0;
        len  <= '0;
      end
    end else if (push && (len < LEN_MAX)) begin
      insn[8*len +: 8] <= push_byte;
      len              <= len + 3'd1;
    end
  end

endmodule

// File: rtl/z80fi_trace_gen.sv
// ---------------------------------------------------------------------------
// z80fi_trace_gen
//   Builds one retired-instruction record per Z80 instruction: the bytes
//   fetched, their count, and the register file at start and at retire.
//   The record is published for one cycle after insn_done and held between
//   records.
//
// Optional feature (macro Z80FI_TRACE_ERR_EN):
//   adds the sticky z80fi_error output, set on byte overflow, on insn_done
//   with no open instruction, and on an abandoned instruction.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   insn_start      : first M1 fetch of an instruction begins
//   fetch_valid     : qualifies fetch_byte
//   fetch_byte      : instruction byte consumed by the current instruction
//   insn_done       : instruction retires this cycle
//   regs_cur        : committed registers (retiring writes visible)
//   z80fi_valid     : one-cycle record strobe
//   z80fi_insn      : captured bytes, byte 0 in [7:0], unused bytes zero
//   z80fi_insn_len  : number of bytes captured
//   z80fi_regs_in   : registers at instruction start
//   z80fi_regs_out  : registers at retire
//   z80fi_error     : sticky error flag (only with Z80FI_TRACE_ERR_EN)
// ---------------------------------------------------------------------------
module z80fi_trace_gen
  import z80fi_pkg::*;
#(
  parameter int INSN_BYTES = Z80FI_INSN_MAX_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    insn_start,
  input  logic                    fetch_valid,
  input  logic [7:0]              fetch_byte,
  input  logic                    insn_done,
  input  z80fi_regs_t             regs_cur,
`ifdef Z80FI_TRACE_ERR_EN
  output logic                    z80fi_error,
`endif
  output logic                    z80fi_valid,
  output logic [8*INSN_BYTES-1:0] z80fi_insn,
  output logic [2:0]              z80fi_insn_len,
  output z80fi_regs_t             z80fi_regs_in,
  output z80fi_regs_t             z80fi_regs_out
);

  localparam logic [2:0] LEN_MAX = 3'(INSN_BYTES);

  z80fi_state_e            state;
  z80fi_regs_t             regs_in_q;
  logic                    col_clear;
  logic                    col_push;
  logic [8*INSN_BYTES-1:0] col_insn;
  logic [2:0]              col_len;
  logic [8*INSN_BYTES-1:0] rec_insn;
  logic [2:0]              rec_len;

  // A start always opens a fresh buffer; a fetch counts only while an
  // instruction is open or is being opened in the same cycle.
  assign col_clear = insn_start;
  assign col_push  = fetch_valid && ((state == COLLECT) || insn_start);

  z80fi_insn_collector #(
    .INSN_BYTES (INSN_BYTES)
  ) u_collector (
    .clk       (clk),
    .reset     (reset),
    .clear     (col_clear),
    .push      (col_push),
    .push_byte (fetch_byte),
    .insn      (col_insn),
    .len       (col_len)
  );

  // Record contents for a retire this cycle. A fetch byte arriving with
  // insn_done belongs to the retiring instruction, unless insn_start is also
  // high, in which case it is byte 0 of the next one.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rec_insn = col_insn;
    rec_len  = col_len;
    if (fetch_valid && !insn_start && (col_len < LEN_MAX)) begin
      rec_insn[8*col_len +: 8] = fetch_byte;
      rec_len                  = col_len + 3'd1;
    end
  end

`ifdef Z80FI_TRACE_ERR_EN
  logic overflow;
  assign overflow = col_push && !col_clear && (col_len == LEN_MAX);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      regs_in_q      <= '0;
      z80fi_valid    <= 1'b0;
      z80fi_insn     <= '0;
      z80fi_insn_len <= '0;
      z80fi_regs_in  <= '0;
      z80fi_regs_out <= '0;
`ifdef Z80FI_TRACE_ERR_EN
      z80fi_error    <= 1'b0;
`endif
    end else begin
      z80fi_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (insn_start) begin
            state     <= COLLECT;
            regs_in_q <= regs_cur;
          end
`ifdef Z80FI_TRACE_ERR_EN
          if (insn_done) z80fi_error <= 1'b1;
`endif
        end
        COLLECT: begin
          if (insn_done) begin
            z80fi_valid    <= 1'b1;
            z80fi_insn     <= rec_insn;
            z80fi_insn_len <= rec_len;
            z80fi_regs_in  <= regs_in_q;
            z80fi_regs_out <= regs_cur;
          end
          // Back-to-back retire/start: the new instruction starts from the
          // retiring one's final registers, and collection continues.
          if (insn_start) begin
            regs_in_q <= regs_cur;
          end else if (insn_done) begin
            state <= IDLE;
          end
`ifdef Z80FI_TRACE_ERR_EN
          if (insn_start && !insn_done) z80fi_error <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef Z80FI_TRACE_ERR_EN
      if (overflow) z80fi_error <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/z80fi_trace_gen.md
Z80FI_TRACE_GEN -- requirements
Module: z80fi_trace_gen

Interface
REQ-001 SHALL have parameter INSN_BYTES, default 4, the maximum instruction bytes captured.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port insn_start, input, 1; the core pulses it in the cycle the M1 fetch of an instruction's first byte begins.
REQ-005 SHALL have port fetch_valid, input, 1; it qualifies fetch_byte.
REQ-006 SHALL have port fetch_byte, input, 8; an opcode, prefix, displacement or immediate byte consumed by the current instruction.
REQ-007 SHALL have port insn_done, input, 1; the core pulses it in the cycle the instruction retires.
REQ-008 SHALL have port regs_cur, input, z80fi_regs_t; the core's committed architectural registers, with retiring writes already visible in the insn_done cycle.
REQ-009 SHALL have port z80fi_valid, output, 1; it marks one retired-instruction record.
REQ-010 SHALL have port z80fi_insn, output, 8*INSN_BYTES; first byte is in [7:0], second in [15:8], etc., and unused bytes are zero.
REQ-011 SHALL have port z80fi_insn_len, output, 3; the count of bytes captured.
REQ-012 SHALL have ports z80fi_regs_in and z80fi_regs_out, output, z80fi_regs_t; registers at instruction start and at retire.
REQ-013 SHALL have port z80fi_error, output, 1, present only under Z80FI_TRACE_ERR_EN.

Function
REQ-014 SHALL use the states IDLE and COLLECT.
REQ-015 SHALL, in IDLE with insn_start, go to COLLECT, clear the byte buffer and length, and latch regs_cur into the regs_in holding register.
REQ-016 SHALL, in COLLECT with fetch_valid, store fetch_byte at byte index len and increment len, saturating at INSN_BYTES; bytes beyond that are dropped.
REQ-017 SHALL treat a fetch_valid in the same cycle as insn_start as the new instruction's byte 0.
REQ-018 SHALL, in COLLECT with insn_done, include any same-cycle fetch byte, latch regs_cur as regs_out, and return to IDLE.
REQ-019 SHALL assert z80fi_valid for exactly one cycle, in the cycle after insn_done, with z80fi_insn, z80fi_insn_len, z80fi_regs_in and z80fi_regs_out stable and consistent in that cycle.
REQ-020 SHALL hold the record outputs at their last values while z80fi_valid is low.
REQ-021 SHALL, when insn_done and insn_start occur in the same cycle, retire the current instruction and open the next one; the next instruction's regs_in then equals the current one's regs_out, and the state stays COLLECT.
REQ-022 SHALL ignore insn_done in IDLE and produce no valid.
REQ-023 SHALL, on insn_start in COLLECT without insn_done, abandon the current instruction with no valid and restart collection per REQ-015.
REQ-024 SHALL ignore fetch_valid in IDLE unless insn_start is also high.

Reset
REQ-025 SHALL, while reset is high, set the state to IDLE and z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in, z80fi_regs_out and z80fi_error to 0.
REQ-026 SHALL, when reset is asserted mid-COLLECT, discard the partial instruction and emit no valid for it.
REQ-027 SHALL give reset priority over all other inputs in the same cycle.

Configuration
REQ-028 SHALL, with Z80FI_TRACE_ERR_EN defined, set the sticky z80fi_error (cleared only by reset) on byte overflow, on insn_done in IDLE, or on an abandoned instruction.
REQ-029 SHALL, without Z80FI_TRACE_ERR_EN, omit the z80fi_error port and logic and leave all other behaviour identical.

Structure
REQ-030 SHALL take z80fi_regs_t (a packed struct of ip, sp, af, bc, de, hl, af2, bc2, de2, hl2, ix, iy, i, r, iff1, iff2, im) from a shared package z80fi_pkg.
REQ-031 SHALL take the state enum and the default constant Z80FI_INSN_MAX_BYTES=4 from z80fi_pkg.
REQ-032 SHALL place byte buffer and length logic in one sub-module, z80fi_insn_collector, with ports clear, push, byte, insn and len.

Verification
REQ-033 SHALL cover INC IX: insn_start with ix=16'h1234, ip=16'h0100; fetch DD,23; insn_done with ix=16'h1235, ip=16'h0102. Required: one-cycle valid, insn=32'h000023DD, len=2, regs_in.ix=1234, regs_out.ix=1235.
REQ-034 SHALL cover DEC IY: fetch FD,2B with iy=16'h0000 → 16'hFFFF. Required: insn=32'h00002BFD, regs_out.iy=16'hFFFF.
REQ-035 SHALL cover two back-to-back NOPs (fetch 00), with done and start in the same cycle. Required: two valids, each len=1, insn=0, and the second regs_in equal to the first regs_out.
REQ-036 SHALL cover an overflow: 5 bytes DD,CB,05,06,AA before done. Required: len=4, insn=32'h0605CBDD, and z80fi_error=1 under Z80FI_TRACE_ERR_EN.
REQ-037 SHALL cover reset after 1 byte of DD, followed by a fresh NOP. Required: no valid for the DD, then a valid with len=1, insn=0.
REQ-038 SHALL cover insn_done in IDLE. Required: no valid, and z80fi_error=1 only when Z80FI_TRACE_ERR_EN is defined.
